// File: rtl/lfsr_bist_ctrl.sv
// BIST sequencer for the serial LFSR test channel: resets the tested LFSR, loops
// LFSR0 back through LFSR1 with optional error injection, and checks both streams.
module lfsr_bist_ctrl #(
  parameter int unsigned RUN_CYCLES = 1024,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned LOOP_LAT   = 1,
  parameter logic [31:0] SEED       = 32'h0000_0001
) (
  input  logic        Clk,
  input  logic        ARstb,
  input  logic        Start,
  input  logic        InjErr,
  output logic        LfsrRstb,
  input  logic        Lfsr0Out,
  output logic        LoopOut,
  input  logic        Lfsr1Out,
  output logic        Busy,
  output logic        Done,
  output logic        Pass,
  output logic [15:0] ErrCount
);

  localparam int unsigned RUN_LEN = RUN_CYCLES + LOOP_LAT;
  localparam int unsigned DLY_W   = (LOOP_LAT == 0) ? 1 : LOOP_LAT;

  typedef enum logic [1:0] {IDLE, RST, RUN, DONE} state_t;

  state_t           state_q;
  logic [31:0]      cnt_q;
  logic [31:0]      model_q;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             inj_q;
  logic [15:0]      err_q, err_d;
  logic             pass_q, done_q, busy_q, lrstb_q;
  logic             ref_b, chk_a, chk_b;
  logic [1:0]       inc;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Delay line of reference bits aligned to the loopback latency
  if (DLY_W > 1) begin : g_dly
    assign dly_d = {dly_q[DLY_W-2:0], model_q[31]};
  end else begin : g_dly1
    assign dly_d = model_q[31];
  end

  always_comb begin
    ref_b = (LOOP_LAT == 0) ? model_q[31] : dly_q[DLY_W-1];
    chk_a = (state_q == RUN) && (cnt_q < RUN_CYCLES) && (Lfsr0Out != model_q[31]);
    chk_b = (state_q == RUN) && (cnt_q >= LOOP_LAT) && (Lfsr1Out != ref_b);
    inc   = {1'b0, chk_a} + {1'b0, chk_b};
    err_d = sat_add(err_q, inc);
  end

  always_ff @(posedge Clk or negedge ARstb) begin
    if (!ARstb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      model_q <= SEED;
      dly_q   <= '0;
      inj_q   <= 1'b0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      lrstb_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      inj_q  <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (Start) begin
            state_q <= RST;
            cnt_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            lrstb_q <= 1'b0;
          end
        end
        RST: begin
          model_q <= SEED;
          dly_q   <= '0;
          if (cnt_q == RST_CYCLES - 1) begin
            state_q <= RUN;
            cnt_q   <= '0;
            lrstb_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1;
          end
        end
        RUN: begin
          model_q <= lfsr_next(model_q);
          dly_q   <= dly_d;
          err_q   <= err_d;
          // An injection requested on the last compared bit would never be checked
          inj_q   <= InjErr && (cnt_q < RUN_CYCLES - 1);
          if (cnt_q == RUN_LEN - 1) begin
            state_q <= DONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 16'd0);
          end else begin
            cnt_q <= cnt_q + 1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign LoopOut  = Lfsr0Out ^ inj_q;
  assign LfsrRstb = lrstb_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Pass     = pass_q;
  assign ErrCount = err_q;

endmodule

// File: tb/tb_lfsr_bist_ctrl.sv
// Directed bench for lfsr_bist_ctrl with behavioural lfsr32 models and a saturating
// second instance (RUN_CYCLES=40000, inverted LFSR0 stream).
module tb_lfsr_bist_ctrl;

  localparam logic [31:0] SEED = 32'h0000_0001;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        ARstb, Start, InjErr, Lfsr0Out, Lfsr1Out;
  logic        LfsrRstb, LoopOut, Busy, Done, Pass;
  logic [15:0] ErrCount;

  logic        Start2, InjErr2, Lfsr0Out2, Lfsr1Out2;
  logic        LfsrRstb2, LoopOut2, Busy2, Done2, Pass2;
  logic [15:0] ErrCount2;

  lfsr_bist_ctrl #(.RUN_CYCLES(1024), .RST_CYCLES(4), .LOOP_LAT(1), .SEED(SEED)) dut (
    .Clk(Clk), .ARstb(ARstb), .Start(Start), .InjErr(InjErr), .LfsrRstb(LfsrRstb),
    .Lfsr0Out(Lfsr0Out), .LoopOut(LoopOut), .Lfsr1Out(Lfsr1Out), .Busy(Busy),
    .Done(Done), .Pass(Pass), .ErrCount(ErrCount)
  );

  lfsr_bist_ctrl #(.RUN_CYCLES(40000), .RST_CYCLES(4), .LOOP_LAT(1), .SEED(SEED)) dut_sat (
    .Clk(Clk), .ARstb(ARstb), .Start(Start2), .InjErr(InjErr2), .LfsrRstb(LfsrRstb2),
    .Lfsr0Out(Lfsr0Out2), .LoopOut(LoopOut2), .Lfsr1Out(Lfsr1Out2), .Busy(Busy2),
    .Done(Done2), .Pass(Pass2), .ErrCount(ErrCount2)
  );

  int nvec = 0;
  int nmis = 0;

  logic [31:0] l0, l1, l0b, l1b;
  int  mode;        // 0: LFSR0 behaves normally, 1: LFSR0 output stuck at 0
  int  inj_r0, inj_r1, inj_r2, abort_r;
  bit  hold_start;
  int  diff_cnt;

  function automatic logic [31:0] nxt(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; behavioural LFSRs mimic async-reset flops sampling pre-edge values
  task automatic tick();
    bit pre_rstb, pre_loop, pre_rstb2, pre_loop2;
    @(negedge Clk);
    pre_rstb  = LfsrRstb;
    pre_loop  = LoopOut;
    pre_rstb2 = LfsrRstb2;
    pre_loop2 = LoopOut2;
    if (LoopOut !== Lfsr0Out) diff_cnt++;
    @(posedge Clk);
    #1;
    if (!LfsrRstb) l0 = SEED;
    else if (pre_rstb) l0 = nxt(l0);
    l1 = {31'd0, pre_loop};
    if (!LfsrRstb2) l0b = SEED;
    else if (pre_rstb2) l0b = nxt(l0b);
    l1b = {31'd0, pre_loop2};
    Lfsr0Out  = (mode == 1) ? 1'b0 : l0[31];
    Lfsr1Out  = l1[0];
    Lfsr0Out2 = ~l0b[31];
    Lfsr1Out2 = l1b[0];
  endtask

  // Cycle c = 1 is the first cycle after the edge that samples Start; r = c - 5.
  task automatic run_to_done(input int c_start, output int lat, output int rlow,
                             output int ndone, output bit aborted);
    int  r;
    bit  fin;
    lat = 0; rlow = 0; ndone = 0; aborted = 0; fin = 0;
    diff_cnt = 0;
    if (c_start == 1) Start = 1'b1;
    for (int c = c_start; c <= 3000 && !fin; c++) begin
      tick();
      if (!hold_start) Start = 1'b0;
      r = c - 5;
      InjErr = (r == inj_r0) || (r == inj_r1) || (r == inj_r2);
      if (!LfsrRstb) rlow++;
      if (Done) begin
        ndone++;
        lat = c;
        fin = 1;
      end
      if (r == abort_r) begin
        ARstb = 1'b0;
        #1;
        aborted = 1;
        fin = 1;
      end
    end
    InjErr = 1'b0;
  endtask

  initial begin
    int  lat, rlow, ndone, ones, dcount;
    bit  ab;
    logic [31:0] s;

    ARstb = 1'b0; Start = 1'b0; InjErr = 1'b0; Start2 = 1'b0; InjErr2 = 1'b0;
    l0 = SEED; l1 = '0; l0b = SEED; l1b = '0;
    Lfsr0Out = 1'b0; Lfsr1Out = 1'b0; Lfsr0Out2 = 1'b1; Lfsr1Out2 = 1'b0;
    mode = 0; inj_r0 = -100; inj_r1 = -100; inj_r2 = -100; abort_r = -100;
    hold_start = 0; diff_cnt = 0;

    // Reset state
    #12;
    check("rst_lfsrrstb", {31'd0, LfsrRstb}, 32'd1);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_pass", {31'd0, Pass}, 32'd0);
    check("rst_errcount", {16'd0, ErrCount}, 32'd0);
    check("rst_loopout", {31'd0, LoopOut}, 32'd0);
    tick();
    ARstb = 1'b1;
    tick(); tick();

    // Clean run
    run_to_done(1, lat, rlow, ndone, ab);
    check("clean_latency", lat, 32'd1030);
    check("clean_rstb_low", rlow, 32'd4);
    check("clean_errcount", {16'd0, ErrCount}, 32'd0);
    check("clean_pass", {31'd0, Pass}, 32'd1);
    check("clean_loop_diff", diff_cnt, 32'd0);
    tick();
    check("done_one_cycle", {31'd0, Done}, 32'd0);
    check("pass_holds", {31'd0, Pass}, 32'd1);

    // Single injection at r=100; requests at r=1023/1024 must be ignored
    inj_r0 = 100; inj_r1 = 1023; inj_r2 = 1024;
    run_to_done(1, lat, rlow, ndone, ab);
    inj_r0 = -100; inj_r1 = -100; inj_r2 = -100;
    check("inj_latency", lat, 32'd1030);
    check("inj_errcount", {16'd0, ErrCount}, 32'd1);
    check("inj_pass", {31'd0, Pass}, 32'd0);
    check("inj_loop_diff", diff_cnt, 32'd1);

    // Lfsr0Out stuck at 0
    s = SEED; ones = 0;
    for (int i = 0; i < 1024; i++) begin
      ones += int'(s[31]);
      s = nxt(s);
    end
    mode = 1;
    run_to_done(1, lat, rlow, ndone, ab);
    check("stuck_latency", lat, 32'd1030);
    check("stuck_errcount", {16'd0, ErrCount}, 2 * ones);
    check("stuck_pass", {31'd0, Pass}, 32'd0);

    // Start held high throughout: one test, then restart from DONE clears ErrCount
    hold_start = 1;
    run_to_done(1, lat, rlow, ndone, ab);
    check("cont_latency", lat, 32'd1030);
    check("cont_ndone", ndone, 32'd1);
    check("cont_errcount", {16'd0, ErrCount}, 2 * ones);
    tick();
    check("cont_restart_busy", {31'd0, Busy}, 32'd1);
    check("cont_restart_rstb", {31'd0, LfsrRstb}, 32'd0);
    check("cont_restart_err", {16'd0, ErrCount}, 32'd0);
    check("cont_restart_done", {31'd0, Done}, 32'd0);
    hold_start = 0; Start = 1'b0; mode = 0;
    run_to_done(2, lat, rlow, ndone, ab);
    check("cont2_latency", lat, 32'd1030);
    check("cont2_pass", {31'd0, Pass}, 32'd1);

    // Asynchronous reset at r=500 of a failing test
    mode = 1; abort_r = 500;
    run_to_done(1, lat, rlow, ndone, ab);
    abort_r = -100;
    check("abort_reached", {31'd0, ab}, 32'd1);
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_rstb", {31'd0, LfsrRstb}, 32'd1);
    check("abort_errcount", {16'd0, ErrCount}, 32'd0);
    check("abort_pass", {31'd0, Pass}, 32'd0);
    check("abort_done", {31'd0, Done}, 32'd0);
    tick(); tick();
    ARstb = 1'b1;
    dcount = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (Done) dcount++;
    end
    check("abort_no_done", dcount, 32'd0);
    mode = 0;
    run_to_done(1, lat, rlow, ndone, ab);
    check("after_abort_latency", lat, 32'd1030);
    check("after_abort_pass", {31'd0, Pass}, 32'd1);
    check("after_abort_err", {16'd0, ErrCount}, 32'd0);

    // Saturation: 40000-bit run with inverted LFSR0 stream
    lat = 0;
    Start2 = 1'b1;
    for (int c = 1; c <= 41000 && lat == 0; c++) begin
      tick();
      Start2 = 1'b0;
      if (Done2) lat = c;
    end
    check("sat_latency", lat, 32'd40006);
    check("sat_errcount", {16'd0, ErrCount2}, 32'h0000_FFFF);
    check("sat_pass", {31'd0, Pass2}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
